training_scheduler: RTL

TRAINING_SCHEDULER -- requirements
Module: training_scheduler

---
 rtl/training_scheduler.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/training_scheduler.sv
// Perceptron training sequencer: streams samples from a memory into a perceptron,
// counts mispredictions per epoch and stops on a clean epoch or the epoch limit.
module training_scheduler #(
  parameter int unsigned N          = 8,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned MAX_EPOCHS = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   num_samples,
  input  logic [31:0]       learning_rate,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [N-2:0]      mem_x,
  input  logic [31:0]       mem_y,
  output logic [N-2:0]      p_x,
  output logic [31:0]       p_expected_y,
  output logic [31:0]       p_learning_rate,
  output logic              p_train,
  input  logic [31:0]       p_y,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic [15:0]       epoch_count,
  output logic [ADDR_W:0]   error_count
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CW    = ADDR_W + 1;
  localparam int unsigned XW    = N - 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [15:0]   MAX_C   = 16'(MAX_EPOCHS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_APPLY,
    S_SETTLE,
    S_EPOCH_END,
    S_DONE
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
  logic [ADDR_W-1:0]   r_last_addr, w_last_addr_nxt;
  logic [XW-1:0]       r_p_x, w_p_x_nxt;
  logic [31:0]         r_p_expected_y, w_p_expected_y_nxt;
  logic [31:0]         r_p_learning_rate, w_p_learning_rate_nxt;
  logic                r_p_train, w_p_train_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic                r_converged, w_converged_nxt;
  logic [15:0]         r_epoch_count, w_epoch_count_nxt;
  logic [CW-1:0]       r_error_count, w_error_count_nxt;
  logic [CW-1:0]       w_num;
  logic [ADDR_W-1:0]   w_last;
  logic [15:0]         w_epoch_inc;

  // Clamp requested sample count into 1..DEPTH and derive the last index.
  always_comb begin
    if (num_samples == '0) begin
      w_num = CW'(1);
    end else if (num_samples > DEPTH_C) begin
      w_num = DEPTH_C;
    end else begin
      w_num = num_samples;
    end
  end

  assign w_last      = ADDR_W'(w_num - CW'(1));
  assign w_epoch_inc = r_epoch_count + 16'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state           <= S_IDLE;
      r_mem_addr        <= '0;
      r_last_addr       <= '0;
      r_p_x             <= '0;
      r_p_expected_y    <= '0;
      r_p_learning_rate <= '0;
      r_p_train         <= 1'b0;
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
      r_converged       <= 1'b0;
      r_epoch_count     <= '0;
      r_error_count     <= '0;
    end else begin
      r_state           <= w_state_nxt;
      r_mem_addr        <= w_mem_addr_nxt;
      r_last_addr       <= w_last_addr_nxt;
      r_p_x             <= w_p_x_nxt;
      r_p_expected_y    <= w_p_expected_y_nxt;
      r_p_learning_rate <= w_p_learning_rate_nxt;
      r_p_train         <= w_p_train_nxt;
      r_busy            <= w_busy_nxt;
      r_done            <= w_done_nxt;
      r_converged       <= w_converged_nxt;
      r_epoch_count     <= w_epoch_count_nxt;
      r_error_count     <= w_error_count_nxt;
    end
  end

  // Next-state and datapath; abort overrides every other transition.
  always_comb begin
    w_state_nxt           = r_state;
    w_mem_addr_nxt        = r_mem_addr;
    w_last_addr_nxt       = r_last_addr;
    w_p_x_nxt             = r_p_x;
    w_p_expected_y_nxt    = r_p_expected_y;
    w_p_learning_rate_nxt = r_p_learning_rate;
    w_p_train_nxt         = 1'b0;
    w_converged_nxt       = r_converged;
    w_epoch_count_nxt     = r_epoch_count;
    w_error_count_nxt     = r_error_count;

    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            w_last_addr_nxt       = w_last;
            w_p_learning_rate_nxt = learning_rate;
            w_mem_addr_nxt        = '0;
            w_epoch_count_nxt     = '0;
            w_error_count_nxt     = '0;
            w_converged_nxt       = 1'b0;
            w_state_nxt           = S_FETCH;
          end
        end
        S_FETCH: begin
          w_state_nxt = S_APPLY;
        end
        S_APPLY: begin
          w_p_x_nxt          = mem_x;
          w_p_expected_y_nxt = mem_y;
          w_p_train_nxt      = 1'b1;
          w_state_nxt        = S_SETTLE;
        end
        S_SETTLE: begin
          if ((p_y != r_p_expected_y) && (r_error_count != DEPTH_C)) begin
            w_error_count_nxt = r_error_count + CW'(1);
          end
          if (r_mem_addr == r_last_addr) begin
            w_state_nxt = S_EPOCH_END;
          end else begin
            w_mem_addr_nxt = r_mem_addr + ADDR_W'(1);
            w_state_nxt    = S_FETCH;
          end
        end
        S_EPOCH_END: begin
          w_epoch_count_nxt = w_epoch_inc;
          if (r_error_count == '0) begin
            w_converged_nxt = 1'b1;
            w_state_nxt     = S_DONE;
          end else if (w_epoch_inc == MAX_C) begin
            w_state_nxt = S_DONE;
          end else begin
            w_error_count_nxt = '0;
            w_mem_addr_nxt    = '0;
            w_state_nxt       = S_FETCH;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end

    w_busy_nxt = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  assign mem_addr        = r_mem_addr;
  assign p_x             = r_p_x;
  assign p_expected_y    = r_p_expected_y;
  assign p_learning_rate = r_p_learning_rate;
  assign p_train         = r_p_train;
  assign busy            = r_busy;
  assign done            = r_done;
  assign converged       = r_converged;
  assign epoch_count     = r_epoch_count;
  assign error_count     = r_error_count;

endmodule
